// File: rtl/dma_io_requester_pkg.sv
// -----------------------------------------------------------------------------
// dma_io_requester_pkg
// Shared DMA types used by the I/O-side requester and its FIFO.
//   DMA_REQ_STATE_e  : requester FSM states
//   DMA_READ_WRITE_e : transfer direction (READ = memory->device,
//                      WRITE = device->memory)
// -----------------------------------------------------------------------------
package dma_io_requester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } DMA_REQ_STATE_e;

  typedef enum logic {
    DMA_READ  = 1'b0,
    DMA_WRITE = 1'b1
  } DMA_READ_WRITE_e;

endpackage

// File: rtl/dma_io_requester_fifo.sv
// -----------------------------------------------------------------------------
// dma_sync_fifo
// First-word-fall-through synchronous FIFO. The head word is presented on
// rd_data_o whenever empty_o is low. Writes when full and reads when empty
// are ignored; a simultaneous read and write both succeed.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wr_en_i, wr_data_i      push request and data
//   rd_en_i, rd_data_o      pop request and head word
//   full_o, empty_o         occupancy flags
//   count_o                 occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module dma_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ok, rd_ok;

  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign count_d   = count_q + CW'(wr_ok) - CW'(rd_ok);
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/dma_io_requester.sv
// -----------------------------------------------------------------------------
// dma_io_requester
// Device-side end of an 8237A-style DREQ/DACK handshake. Raises dreq while the
// local FIFO needs service and commits one byte per DMA strobe rising edge:
//   WRITE mode (device->memory): drives db_out with the FIFO head while ior_n
//                                is low, pops on the ior_n rising edge.
//   READ mode  (memory->device): captures db_in while iow_n is low, pushes on
//                                the iow_n rising edge.
// eop_n low during a strobe ends the process (DONE, tc_done) until restart.
// Optional macro DMA_WATERMARK_EN: in WRITE mode request only once the FIFO
// holds WATERMARK bytes, then keep bursting while any byte remains.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   dreq, dack                  DMA request / acknowledge (configurable polarity)
//   ior_n, iow_n, eop_n         DMA strobes and end-of-process, active low
//   db_in, db_out, db_oe        data bus in, data bus out and its drive enable
//   mode, restart               direction select, one-cycle DONE release
//   lcl_wr_en/_data             local push side
//   lcl_rd_en/_data             local pop side (first-word-fall-through)
//   lcl_full/_empty/_count      FIFO status
//   tc_done, xfer_err           terminal count reached, sticky DMA fault
// -----------------------------------------------------------------------------
module dma_io_requester
  import dma_io_requester_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int DREQ_ACTIVE_LOW = 0,
  parameter int DACK_ACTIVE_LOW = 1,
  parameter int WATERMARK       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        dreq,
  input  logic                        dack,
  input  logic                        ior_n,
  input  logic                        iow_n,
  input  logic                        eop_n,
  input  logic [DATA_WIDTH-1:0]       db_in,
  output logic [DATA_WIDTH-1:0]       db_out,
  output logic                        db_oe,
  input  logic                        mode,
  input  logic                        restart,
  input  logic                        lcl_wr_en,
  input  logic [DATA_WIDTH-1:0]       lcl_wr_data,
  input  logic                        lcl_rd_en,
  output logic [DATA_WIDTH-1:0]       lcl_rd_data,
  output logic                        lcl_full,
  output logic                        lcl_empty,
  output logic [$clog2(FIFO_DEPTH):0] lcl_count,
  output logic                        tc_done,
  output logic                        xfer_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      WATERMARK < 1 || WATERMARK > FIFO_DEPTH) begin : g_bad_param
    $error("dma_io_requester: illegal FIFO_DEPTH/WATERMARK");
  end

  DMA_REQ_STATE_e        state_q, state_d;
  DMA_READ_WRITE_e       mode_q, mode_eff;
  logic                  ior_q, iow_q;
  logic                  eop_seen_q, eop_seen_d;
  logic                  xfer_err_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic          dack_act, wr_mode, strobe_low, dma_edge, dma_commit, eop_hit;
  logic          push_req, pop_req, push_ok, pop_ok, err_set;
  logic          need_now, need_burst;
  logic [CW-1:0] cnt_nxt;
  logic [DATA_WIDTH-1:0] push_data, head;

  assign dack_act = (DACK_ACTIVE_LOW != 0) ? ~dack : dack;

  // Direction follows the mode pin only while idle; otherwise it is frozen.
  assign mode_eff = (state_q == IDLE) ? DMA_READ_WRITE_e'(mode) : mode_q;
  assign wr_mode  = (mode_eff == DMA_WRITE);

  assign strobe_low = wr_mode ? ~ior_n : ~iow_n;
  assign dma_edge   = dack_act && (wr_mode ? (!ior_q && ior_n) : (!iow_q && iow_n));
  assign dma_commit = dma_edge && (state_q == XFER);
  assign eop_hit    = eop_seen_q || !eop_n;

  // The DMA side owns the FIFO end opposite to the local side.
  assign push_req  = wr_mode ? lcl_wr_en : dma_commit;
  assign pop_req   = wr_mode ? dma_commit : lcl_rd_en;
  assign push_data = wr_mode ? lcl_wr_data : hold_q;
  assign push_ok   = push_req && !lcl_full;
  assign pop_ok    = pop_req && !lcl_empty;
  assign cnt_nxt   = lcl_count + CW'(push_ok) - CW'(pop_ok);

  // Any acknowledged strobe that cannot move a byte is a fault, even outside XFER.
  assign err_set = dma_edge && (wr_mode ? lcl_empty : lcl_full);

`ifdef DMA_WATERMARK_EN
  assign need_now = wr_mode ? (lcl_count >= CW'(WATERMARK)) : !lcl_full;
`else
  assign need_now = wr_mode ? (lcl_count != '0) : !lcl_full;
`endif
  // Continuation test uses the post-commit occupancy so dreq drops right after
  // the byte that exhausts (or fills) the FIFO.
  assign need_burst = wr_mode ? (cnt_nxt != '0) : (cnt_nxt != CW'(FIFO_DEPTH));

  dma_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (push_req),
    .wr_data_i (push_data),
    .rd_en_i   (pop_req),
    .rd_data_o (head),
    .full_o    (lcl_full),
    .empty_o   (lcl_empty),
    .count_o   (lcl_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (need_now) state_d = REQ;
      REQ: begin
        if (!need_now)     state_d = IDLE;
        else if (dack_act) state_d = XFER;
      end
      XFER: begin
        if (dma_commit) begin
          if (eop_hit)         state_d = DONE;
          else if (need_burst) state_d = XFER;
          else                 state_d = IDLE;
        end else if (!dack_act) begin
          state_d = need_now ? REQ : IDLE;
        end
      end
      DONE: if (restart) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // eop_n may be low only part of the strobe; remember it until the commit.
  always_comb begin
    eop_seen_d = eop_seen_q;
    if (state_q != XFER || dma_commit)
      eop_seen_d = 1'b0;
    else if (strobe_low && dack_act && !eop_n)
      eop_seen_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= DMA_READ;
      ior_q      <= 1'b1;
      iow_q      <= 1'b1;
      eop_seen_q <= 1'b0;
      xfer_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_eff;
      ior_q      <= ior_n;
      iow_q      <= iow_n;
      eop_seen_q <= eop_seen_d;
      if (err_set) xfer_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!iow_n) hold_q <= db_in;
  end

  assign dreq        = ((state_q == REQ) || (state_q == XFER)) ^ (DREQ_ACTIVE_LOW != 0);
  assign db_oe       = (state_q == XFER) && wr_mode && !ior_n && dack_act;
  assign db_out      = db_oe ? head : '0;
  assign lcl_rd_data = head;
  assign tc_done     = (state_q == DONE);
  assign xfer_err    = xfer_err_q;

endmodule
